// File: rtl/addn_seq_if.sv
// Handshake and operand/result bundle for addn_seq.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface addn_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, out, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, out, cout, ovf
   );
endinterface

// File: rtl/addn_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor, SLICE bits per clock with a registered ripple carry.
// Define ADDN_SAT_EN to saturate the result on signed overflow instead of wrapping.
module addn_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic       clk,
   input logic       reset,
   addn_seq_if.slave bus
);
   localparam int NS    = WIDTH / SLICE;
   localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

   if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("addn_seq: SLICE must be non-zero and divide WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             c_q, c_d;
   logic             sub_q, sub_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [SLICE-1:0] a_slice;
   logic [SLICE-1:0] b_slice;
   logic [SLICE:0]   slice_sum;
   logic [WIDTH-1:0] res_full;
   logic             ovf_now;

   // Subtraction is a + ~b + ~cin, so b and the carry are inverted once at accept time.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      out_d     = out_q;
      idx_d     = idx_q;
      c_d       = c_q;
      sub_d     = sub_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;

      a_slice   = a_q[idx_q*SLICE +: SLICE];
      b_slice   = b_q[idx_q*SLICE +: SLICE];
      slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, c_q};
      res_full  = out_q;
      res_full[idx_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      ovf_now   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_full[WIDTH-1] != a_q[WIDTH-1]);

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               c_d     = bus.cin ^ bus.sub;
               sub_d   = bus.sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            out_d = res_full;
            c_d   = slice_sum[SLICE];
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               cout_d  = slice_sum[SLICE] ^ sub_q;
               ovf_d   = ovf_now;
               state_d = DONE;
`ifdef ADDN_SAT_EN
               // Positive overflow only happens when both operands were non-negative.
               if (ovf_now) begin
                  out_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
               end
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         idx_q   <= '0;
         c_q     <= 1'b0;
         sub_q   <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         sub_q   <= sub_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out       = out_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_addn_seq.sv
// Self-checking bench for addn_seq at WIDTH=16 with SLICE=1, 4 and 16 side by side.
// Honours ADDN_SAT_EN the same way the design does.
module tb_addn_seq;
   localparam int W = 16;

   logic clk = 1'b0;
   logic reset;

   logic [2:0]        in_valid_v, sub_v, cin_v, out_ready_v;
   logic [2:0]        in_ready_v, out_valid_v, cout_v, ovf_v;
   logic [2:0][W-1:0] a_v, b_v, out_v;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int SL = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
      addn_seq_if #(.WIDTH(W)) bus ();
      addn_seq #(.WIDTH(W), .SLICE(SL)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus.slave)
      );
      assign bus.in_valid   = in_valid_v[g];
      assign bus.a          = a_v[g];
      assign bus.b          = b_v[g];
      assign bus.sub        = sub_v[g];
      assign bus.cin        = cin_v[g];
      assign bus.out_ready  = out_ready_v[g];
      assign in_ready_v[g]  = bus.in_ready;
      assign out_valid_v[g] = bus.out_valid;
      assign out_v[g]       = bus.out;
      assign cout_v[g]      = bus.cout;
      assign ovf_v[g]       = bus.ovf;
   end

   typedef struct {
      logic          sub;
      logic          cin;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  exp_out;
      logic          exp_cout;
      logic          exp_ovf;
   } vec_t;

   vec_t vecs[9];

   function automatic int ns_of(input int k);
      return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
   endfunction

   // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c,
                                 output logic [W-1:0] o, output logic co, output logic ov);
      logic [W:0] u;
      int sa, sb, t;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (!s) begin
         u = {1'b0, a} + {1'b0, b} + 17'(c);
         t = sa + sb + int'(c);
      end else begin
         u = {1'b0, a} - {1'b0, b} - 17'(c);
         t = sa - sb - int'(c);
      end
      o  = u[W-1:0];
      co = u[W];
      ov = (t > 32767) || (t < -32768);
`ifdef ADDN_SAT_EN
      if (ov) o = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
   endfunction

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, got, exp);
      end
   endtask

   // Called #1 after a clock edge with instance k idle; returns #1 after the handshake edge.
   task automatic apply_stimulus(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c,
                                 output logic [W-1:0] o, output logic co, output logic ov,
                                 output int lat);
      o   = '0;
      co  = 1'b0;
      ov  = 1'b0;
      lat = 0;
      check_output($sformatf("in_ready before accept k=%0d", k), 32'(in_ready_v[k]), 32'd1);
      in_valid_v[k]  = 1'b1;
      a_v[k]         = a;
      b_v[k]         = b;
      sub_v[k]       = s;
      cin_v[k]       = c;
      out_ready_v[k] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[k] = 1'b0;
      a_v[k]        = 16'($urandom);
      b_v[k]        = 16'($urandom);
      sub_v[k]      = 1'($urandom);
      cin_v[k]      = 1'($urandom);
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (out_valid_v[k]) begin
            lat = n;
            o   = out_v[k];
            co  = cout_v[k];
            ov  = ovf_v[k];
            break;
         end
      end
      if (lat == 0) begin
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
      end else begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #5_000_000;
      failures++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [W-1:0] o, eo;
      logic         co, ov, eco, eov;
      int           lat, seen;

      vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
`ifdef ADDN_SAT_EN
      vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1};
`else
      vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
`endif
      vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFD, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};

      // Reset held with in_valid high must not start an operation.
      reset       = 1'b1;
      in_valid_v  = '1;
      a_v         = {3{16'hFFFF}};
      b_v         = '0;
      sub_v       = '0;
      cin_v       = '0;
      out_ready_v = '1;
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b0;
      in_valid_v = '0;
      for (int k = 0; k < 3; k++) begin
         check_output($sformatf("reset out_valid k=%0d", k), 32'(out_valid_v[k]), 32'd0);
         check_output($sformatf("reset out k=%0d", k), 32'(out_v[k]), 32'h0);
         check_output($sformatf("reset cout k=%0d", k), 32'(cout_v[k]), 32'd0);
         check_output($sformatf("reset ovf k=%0d", k), 32'(ovf_v[k]), 32'd0);
         check_output($sformatf("reset in_ready k=%0d", k), 32'(in_ready_v[k]), 32'd1);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         check_output($sformatf("post-reset idle k=%0d", k), 32'(in_ready_v[k]), 32'd1);
      end

      for (int v = 0; v < 9; v++) begin
         for (int k = 0; k < 3; k++) begin
            apply_stimulus(k, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].cin, o, co, ov, lat);
            check_output($sformatf("vec%0d k=%0d out", v, k), 32'(o), 32'(vecs[v].exp_out));
            check_output($sformatf("vec%0d k=%0d cout", v, k), 32'(co), 32'(vecs[v].exp_cout));
            check_output($sformatf("vec%0d k=%0d ovf", v, k), 32'(ov), 32'(vecs[v].exp_ovf));
            check_output($sformatf("vec%0d k=%0d latency", v, k), 32'(lat), 32'(ns_of(k)));
         end
      end

      // Backpressure in DONE on the SLICE=4 instance while in_valid toggles.
      out_ready_v[1] = 1'b0;
      in_valid_v[1]  = 1'b1;
      a_v[1]         = 16'h1234;
      b_v[1]         = 16'h4321;
      sub_v[1]       = 1'b0;
      cin_v[1]       = 1'b0;
      @(posedge clk); #1;
      in_valid_v[1] = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (out_valid_v[1]) begin
            lat = n;
            break;
         end
      end
      check_output("backpressure latency", 32'(lat), 32'd4);
      for (int n = 0; n < 5; n++) begin
         in_valid_v[1] = ~in_valid_v[1];
         a_v[1]        = 16'($urandom);
         b_v[1]        = 16'($urandom);
         sub_v[1]      = 1'($urandom);
         @(posedge clk); #1;
         check_output($sformatf("bp out_valid c%0d", n), 32'(out_valid_v[1]), 32'd1);
         check_output($sformatf("bp in_ready c%0d", n), 32'(in_ready_v[1]), 32'd0);
         check_output($sformatf("bp out c%0d", n), 32'(out_v[1]), 32'h5555);
         check_output($sformatf("bp cout c%0d", n), 32'(cout_v[1]), 32'd0);
         check_output($sformatf("bp ovf c%0d", n), 32'(ovf_v[1]), 32'd0);
      end
      in_valid_v[1]  = 1'b0;
      out_ready_v[1] = 1'b1;
      @(posedge clk); #1;
      check_output("bp release out_valid", 32'(out_valid_v[1]), 32'd0);
      check_output("bp release in_ready", 32'(in_ready_v[1]), 32'd1);
      check_output("bp idle out held", 32'(out_v[1]), 32'h5555);
      @(posedge clk); #1;
      check_output("bp nothing accepted", 32'(in_ready_v[1]), 32'd1);

      // Reset after two RUN cycles aborts without ever raising out_valid.
      in_valid_v[1] = 1'b1;
      a_v[1]        = 16'h1234;
      b_v[1]        = 16'h4321;
      @(posedge clk); #1;
      in_valid_v[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("abort in RUN", 32'(in_ready_v[1]), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      seen  = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         seen += int'(out_valid_v[1]);
      end
      check_output("abort out_valid count", 32'(seen), 32'd0);
      check_output("abort out cleared", 32'(out_v[1]), 32'h0);
      check_output("abort in_ready", 32'(in_ready_v[1]), 32'd1);

      // Random vectors spread over the three slice widths.
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb;
         logic         rs, rc;
         int           k;
         k  = i % 3;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         model(ra, rb, rs, rc, eo, eco, eov);
         apply_stimulus(k, ra, rb, rs, rc, o, co, ov, lat);
         check_output($sformatf("rand%0d k=%0d %h%s%h c%0d out", i, k, ra, rs ? "-" : "+", rb, rc),
                      32'(o), 32'(eo));
         check_output($sformatf("rand%0d k=%0d cout", i, k), 32'(co), 32'(eco));
         check_output($sformatf("rand%0d k=%0d ovf", i, k), 32'(ov), 32'(eov));
         check_output($sformatf("rand%0d k=%0d latency", i, k), 32'(lat), 32'(ns_of(k)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/addn_seq.md
Name: addn_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands SLICE bits per clock, LSB slice first, with a ripple carry held in a register between slices.
- Valid/ready handshakes on both input and output; reports carry/borrow-out and signed overflow.
- Intended as the area-lean arithmetic unit for wide datapaths in the Hack FPGA build.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SLICE, 4, bits processed per cycle. Must divide WIDTH, else elaboration error. NS = WIDTH/SLICE; SLICE==WIDTH gives NS=1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; equals (state==IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- cin  in  1  carry-in (add) / borrow-in (sub).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  result, registered.
- cout  out  1  carry-out (add) / borrow-out (sub).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (sync, wins over all inputs): state=IDLE, out=0, cout=0, ovf=0, out_valid=0; in_ready=1 from the first cycle after reset.
- A reset during RUN or DONE aborts the operation. No out_valid is produced for the aborted operation.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On in_valid&in_ready, latch a and b_eff (b if sub=0, ~b if sub=1) and the carry register c0 (cin if sub=0, ~cin if sub=1).
  - Clear slice index i=0, then go to RUN.
- RUN:
  - Each cycle, out[i*SLICE +: SLICE] = a_slice + b_eff_slice + c; c updates to the slice carry; i increments.
  - After slice NS-1, go to DONE.
  - cout = final c for add, ~final c for sub.
  - ovf = (a[MSB]==b_eff[MSB]) && (out[MSB]!=a[MSB]).
- Latency: operands accepted at edge k -> out_valid=1 after edge k+NS. in_ready=0 throughout RUN and DONE.
- DONE:
  - out_valid=1. out, cout and ovf are held stable until out_ready=1.
  - The handshake edge returns to IDLE and drops out_valid.
  - No same-cycle re-accept, so maximum throughput is one operation per NS+2 cycles.
- in_valid is ignored outside IDLE. Operand inputs may change freely after the accept edge.
- Wrap-around: the result is modulo 2^WIDTH unless the optional feature is enabled.
- out keeps its last value in IDLE.

Optional Feature:
- ADDN_SAT_EN defined: on ovf=1 the DONE-state out saturates to 0111..1 (positive overflow) or 1000..0 (negative overflow). cout and ovf are reported unchanged.
- ADDN_SAT_EN undefined: out is the wrapped modulo result. No extra logic is generated.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, a=0xFFFF -> out_valid=0, out=0x0000, in_ready=1 on release; no operation started.
- WIDTH=16, SLICE=4, add, a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 cycles after accept, out=0x5555, cout=0, ovf=0. Also a=0xFFFF, b=0x0001 -> 0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, add -> out=0x8000, ovf=1, cout=0. With ADDN_SAT_EN -> out=0x7FFF, ovf=1.
- sub=1, a=0x0005, b=0x0007, cin=0 -> out=0xFFFE, cout=1, ovf=0. Same operands with cin=1 -> out=0xFFFD.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid toggles -> out, cout and ovf stable, in_ready=0, nothing accepted. Then out_ready=1 -> IDLE next cycle.
- Reset asserted after 2 RUN cycles -> no out_valid. Then run 1000 random add/sub vectors, each checked against a+b+cin and a-b-cin at WIDTH=16 with SLICE=1, 4 and 16; zero mismatches required.
